mc_main_fsm: RTL and testbench

- Main control state machine for the multicycle MIPS core; sits directly upstream of the ALU decoder and drives its 2-bit aluop.
- Decodes the 6-bit opcode and sequences the datapath per instruction: fetch, decode, execute, memory, writeback.
- Emits all multiplexer selects and write enables.
- Supported instructions: lw, sw, R-type, beq, addi, j, andi, plus bne when the optional feature is enabled.

---
 rtl/mc_main_fsm.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
// -----------------------------------------------------------------------------
// mc_main_fsm
// Main control state machine of the multicycle MIPS core. Decodes the 6-bit
// opcode and walks each instruction through fetch / decode / execute /
// memory / writeback, producing every datapath mux select and write enable
// plus the 2-bit aluop consumed by the downstream ALU decoder.
//
// Optional feature macro: MC_MAIN_FSM_BNE_EN
//   defined   -> opcode 000101 (bne) executes through BNEEX (encoding 14)
//   undefined -> 000101 is illegal, branchne is constant 0, 14 is unused
//
// Parameters:
//   STATE_W   width of the debug state output (must be >= 4)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset; FSM held in FETCH while low
//   op        in   [5:0] opcode from the instruction register
//   memwrite  out  data memory write enable
//   lord      out  address select (0=PC, 1=ALUOut)
//   irwrite   out  instruction register load
//   pcwrite   out  unconditional PC load
//   branch    out  PC load when zero=1 (beq)
//   branchne  out  PC load when zero=0 (bne)
//   pcsrc     out  [1:0] next-PC select (00=ALUResult, 01=ALUOut, 10=jump)
//   alusrca   out  ALU A select (0=PC, 1=register A)
//   alusrcb   out  [1:0] ALU B select (00=B, 01=4, 10=imm, 11=imm<<2)
//   zeroext   out  immediate extension (1=zero, 0=sign)
//   regdst    out  write register select (0=rt, 1=rd)
//   memtoreg  out  writeback data select (0=ALUOut, 1=memory)
//   regwrite  out  register file write enable
//   aluop     out  [1:0] ALU decoder control (00=add, 01=sub, 10=and, 11=funct)
//   illegal   out  one-cycle pulse in DECODE for an unsupported opcode
//   state     out  [STATE_W-1:0] current state encoding, zero-extended
//
// Outputs are decoded from the state register (Moore), except illegal which
// also looks at op. All outputs except state are held at 0 while reset is
// low, so no PC or IR write can happen during reset; the FETCH outputs show
// up as soon as reset is released.
// -----------------------------------------------------------------------------
module mc_main_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   output logic               memwrite,
   output logic               lord,
   output logic               irwrite,
   output logic               pcwrite,
   output logic               branch,
   output logic               branchne,
   output logic [1:0]         pcsrc,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic               zeroext,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic [1:0]         aluop,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11,
      ANDIEX  = 4'd12,
      ANDIWB  = 4'd13,
      BNEEX   = 4'd14
   } state_t;

   state_t state_q;
   logic   op_legal;

   // Opcode support check, used only for the DECODE illegal pulse.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
         OP_ADDI, OP_J, OP_ANDI:            op_legal = 1'b1;
`ifdef MC_MAIN_FSM_BNE_EN
         OP_BNE:                            op_legal = 1'b1;
`endif
         default:                           op_legal = 1'b0;
      endcase
   end

   // State register. op is only looked at in DECODE and MEMADR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         case (state_q)
            FETCH:   state_q <= DECODE;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_RTYPE:     state_q <= RTYPEEX;
                  OP_BEQ:       state_q <= BEQEX;
                  OP_ADDI:      state_q <= ADDIEX;
                  OP_J:         state_q <= JEX;
                  OP_ANDI:      state_q <= ANDIEX;
`ifdef MC_MAIN_FSM_BNE_EN
                  OP_BNE:       state_q <= BNEEX;
`endif
                  // Unsupported opcode: flagged via illegal, then NOP.
                  default:      state_q <= FETCH;
               endcase
            end
            // Only sw goes to the write path; lw (and anything else that
            // reaches here) takes the read path.
            MEMADR:  state_q <= (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_q <= MEMWB;
            MEMWB:   state_q <= FETCH;
            MEMWR:   state_q <= FETCH;
            RTYPEEX: state_q <= RTYPEWB;
            RTYPEWB: state_q <= FETCH;
            BEQEX:   state_q <= FETCH;
            ADDIEX:  state_q <= ADDIWB;
            ADDIWB:  state_q <= FETCH;
            JEX:     state_q <= FETCH;
            ANDIEX:  state_q <= ANDIWB;
            ANDIWB:  state_q <= FETCH;
            // Unused encodings (and BNEEX) recover to FETCH.
            default: state_q <= FETCH;
         endcase
      end
   end

   // Output decode. Everything defaults to 0 and is gated by reset.
   always_comb begin
      memwrite = 1'b0;
      lord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      branchne = 1'b0;
      pcsrc    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      zeroext  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      aluop    = 2'b00;
      illegal  = 1'b0;
      if (reset) begin
         case (state_q)
            FETCH: begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               alusrcb = 2'b01;
            end
            DECODE: begin
               alusrcb = 2'b11;
               illegal = ~op_legal;
            end
            MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            MEMRD: lord = 1'b1;
            MEMWB: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
            end
            MEMWR: begin
               lord     = 1'b1;
               memwrite = 1'b1;
            end
            RTYPEEX: begin
               alusrca = 1'b1;
               aluop   = 2'b11;
            end
            RTYPEWB: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            BEQEX: begin
               alusrca = 1'b1;
               aluop   = 2'b01;
               pcsrc   = 2'b01;
               branch  = 1'b1;
            end
            ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
               pcsrc   = 2'b10;
               pcwrite = 1'b1;
            end
            ANDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               aluop   = 2'b10;
               zeroext = 1'b1;
            end
            ANDIWB: regwrite = 1'b1;
`ifdef MC_MAIN_FSM_BNE_EN
            BNEEX: begin
               alusrca  = 1'b1;
               aluop    = 2'b01;
               pcsrc    = 2'b01;
               branchne = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_main_fsm
// Directed instruction walks with literal state/output expectations, then a
// randomized opcode stream with occasional asynchronous resets. A queue-based
// instruction model predicts the state sequence; a per-cycle compare process
// checks state and every control output against it.
// -----------------------------------------------------------------------------
module tb_mc_main_fsm;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] ANDI = 6'b001100;

`ifdef MC_MAIN_FSM_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] op = LW;
   logic       memwrite, lord, irwrite, pcwrite, branch, branchne;
   logic [1:0] pcsrc, alusrcb, aluop;
   logic       alusrca, zeroext, regdst, memtoreg, regwrite, illegal;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   mc_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op),
      .memwrite(memwrite), .lord(lord), .irwrite(irwrite), .pcwrite(pcwrite),
      .branch(branch), .branchne(branchne), .pcsrc(pcsrc), .alusrca(alusrca),
      .alusrcb(alusrcb), .zeroext(zeroext), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .aluop(aluop),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   logic [17:0] dut_vec;
   assign dut_vec = {memwrite, lord, irwrite, pcwrite, branch, branchne, pcsrc,
                     alusrca, alusrcb, zeroext, regdst, memtoreg, regwrite,
                     aluop, illegal};

   function automatic bit is_legal(input logic [5:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
             (o == ADDI) || (o == JMP) || (o == ANDI) || (BNE_EN && o == BNE);
   endfunction

   // Expected control outputs for a state, straight from the state table.
   function automatic logic [17:0] exp_vec(input int s, input logic [5:0] o,
                                           input logic rst_n);
      logic       mw, lo, ir, pw, br, bn, asa, ze, rd, mt, rw, ill;
      logic [1:0] pcs, asb, aop;
      {mw, lo, ir, pw, br, bn, asa, ze, rd, mt, rw, ill} = '0;
      pcs = 2'd0; asb = 2'd0; aop = 2'd0;
      case (s)
         0:  begin ir = 1; pw = 1; asb = 2'd1; end
         1:  begin asb = 2'd3; ill = !is_legal(o); end
         2:  begin asa = 1; asb = 2'd2; end
         3:  lo = 1;
         4:  begin mt = 1; rw = 1; end
         5:  begin lo = 1; mw = 1; end
         6:  begin asa = 1; aop = 2'd3; end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; aop = 2'd1; pcs = 2'd1; br = 1; end
         9:  begin asa = 1; asb = 2'd2; end
         10: rw = 1;
         11: begin pcs = 2'd2; pw = 1; end
         12: begin asa = 1; asb = 2'd2; aop = 2'd2; ze = 1; end
         13: rw = 1;
         14: if (BNE_EN) begin asa = 1; aop = 2'd1; pcs = 2'd1; bn = 1; end
         default: ;
      endcase
      if (!rst_n) return 18'd0;
      return {mw, lo, ir, pw, br, bn, pcs, asa, asb, ze, rd, mt, rw, aop, ill};
   endfunction

   // Instruction-level model: DECODE (and MEMADR for loads/stores) pushes the
   // remaining states of the instruction; an empty path means back to FETCH.
   int m_state = 0;
   int path_q[$];

   task automatic take_path();
      if (path_q.size() != 0) m_state = path_q.pop_front();
      else                    m_state = 0;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state = 0;
         path_q.delete();
      end else if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (op == LW || op == SW)        path_q.push_back(2);
         else if (op == RT)   begin path_q.push_back(6); path_q.push_back(7); end
         else if (op == BEQ)              path_q.push_back(8);
         else if (op == ADDI) begin path_q.push_back(9); path_q.push_back(10); end
         else if (op == JMP)              path_q.push_back(11);
         else if (op == ANDI) begin path_q.push_back(12); path_q.push_back(13); end
         else if (BNE_EN && op == BNE)    path_q.push_back(14);
         take_path();
      end else if (m_state == 2) begin
         if (op == LW) begin path_q.push_back(3); path_q.push_back(4); end
         else          path_q.push_back(5);
         take_path();
      end else begin
         take_path();
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      checks++;
      if (state !== 4'(m_state)) begin
         errors++;
         $display("FAIL state @%0t: got %0d expected %0d", $time, state, m_state);
      end
      checks++;
      if (dut_vec !== exp_vec(m_state, op, reset)) begin
         errors++;
         $display("FAIL outputs @%0t (state %0d op %b): got %b expected %b",
                  $time, m_state, op, dut_vec, exp_vec(m_state, op, reset));
      end
   end

   // Literal expectations that pin the model.
   task automatic step(input string name, input int exp_s);
      @(negedge clk);
      checks++;
      if (state !== 4'(exp_s)) begin
         errors++;
         $display("FAIL %s_state: got %0d expected %0d", name, state, exp_s);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [5:0] op_tab [10];

   initial begin
      // Reset held for 3 cycles; outputs must stay quiet.
      reset = 1'b0;
      op    = LW;
      repeat (3) begin
         @(negedge clk);
         pin("reset_outputs", 32'(dut_vec), 32'd0);
         pin("reset_state", 32'(state), 32'd0);
      end
      @(posedge clk); #2 reset = 1'b1;

      // lw: 0,1,2,3,4,0
      step("lw", 0); pin("lw_irwrite", 32'(irwrite), 1); pin("lw_pcwrite", 32'(pcwrite), 1);
      step("lw", 1); step("lw", 2); step("lw", 3);
      step("lw", 4); pin("lw_regwrite", 32'(regwrite), 1); pin("lw_memtoreg", 32'(memtoreg), 1);
      step("lw", 0);
      // sw: 1,2,5,0
      op = SW;
      step("sw", 1); step("sw", 2);
      step("sw", 5); pin("sw_memwrite", 32'(memwrite), 1); pin("sw_lord", 32'(lord), 1);
      pin("sw_regwrite", 32'(regwrite), 0);
      step("sw", 0);
      // andi: 1,12,13,0
      op = ANDI;
      step("andi", 1);
      step("andi", 12); pin("andi_aluop", 32'(aluop), 2); pin("andi_alusrcb", 32'(alusrcb), 2);
      pin("andi_zeroext", 32'(zeroext), 1);
      step("andi", 13); step("andi", 0);
      // R-type: 1,6,7,0
      op = RT;
      step("rtype", 1);
      step("rtype", 6); pin("rtype_aluop", 32'(aluop), 3);
      step("rtype", 7); pin("rtype_regdst", 32'(regdst), 1); pin("rtype_regwrite", 32'(regwrite), 1);
      step("rtype", 0);
      // beq: 1,8,0
      op = BEQ;
      step("beq", 1);
      step("beq", 8); pin("beq_branch", 32'(branch), 1); pin("beq_pcsrc", 32'(pcsrc), 1);
      pin("beq_aluop", 32'(aluop), 1);
      step("beq", 0);
      // j: 1,11,0
      op = JMP;
      step("j", 1);
      step("j", 11); pin("j_pcwrite", 32'(pcwrite), 1); pin("j_pcsrc", 32'(pcsrc), 2);
      step("j", 0);
      // illegal opcode: one-cycle pulse in DECODE
      op = 6'b111111;
      step("ill", 1); pin("ill_pulse", 32'(illegal), 1);
      step("ill", 0); pin("ill_clear", 32'(illegal), 0);
      // bne
      op = BNE;
      step("bne", 1);
`ifdef MC_MAIN_FSM_BNE_EN
      pin("bne_illegal", 32'(illegal), 0);
      step("bne", 14); pin("bne_branchne", 32'(branchne), 1);
      step("bne", 0);
`else
      pin("bne_illegal", 32'(illegal), 1);
      step("bne", 0); pin("bne_branchne", 32'(branchne), 0);
`endif
      // Asynchronous reset mid-instruction while in MEMRD.
      op = LW;
      step("mid", 1); step("mid", 2); step("mid", 3);
      #2 reset = 1'b0;
      #1 pin("mid_rst_state", 32'(state), 0);
      pin("mid_rst_outputs", 32'(dut_vec), 0);
      @(posedge clk); #2 reset = 1'b1;
      step("mid_resume", 0);
      pin("mid_irwrite", 32'(irwrite), 1); pin("mid_pcwrite", 32'(pcwrite), 1);

      // Random opcode stream; op changes every cycle, checked by the model.
      op_tab = '{LW, SW, RT, BEQ, ADDI, JMP, ANDI, BNE, 6'b111111, 6'b010001};
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if (m_state == 2) op = ($urandom_range(0, 1) != 0) ? LW : SW;
         else if ($urandom_range(0, 9) == 0) op = 6'($urandom);
         else op = op_tab[$urandom_range(0, 9)];
         if ($urandom_range(0, 199) == 0) begin
            #1 reset = 1'b0;
            @(posedge clk); #2 reset = 1'b1;
         end
      end
      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
